// File: rtl/amostrador_pkg.sv
// Shared types for the input sampler: state encoding, idle code, counter sizing.
// Optional auto-repeat is enabled by defining AMOSTRADOR_REPEAT_EN.
package amostrador_pkg;

  localparam int CODE_W = 7;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    FILTRANDO = 2'd1,
    EMITIDO   = 2'd2,
    LIBERANDO = 2'd3
  } estado_t;

  localparam logic [CODE_W-1:0] CODE_IDLE = '0;

  // Counter width able to hold max(a,b) without wrapping.
  function automatic int cnt_bits(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/amostrador_if.sv
// Code-line bundle between raw keypad lines and the sequence decoder.
// master drives Bruto and reads results; slave is the sampler.
interface amostrador_if #(
  parameter int WIDTH = 7
);

  logic [WIDTH-1:0] Bruto;
  logic [WIDTH-1:0] Entrada;
  logic             Controle;
  logic             Pressionado;

  modport master (
    output Bruto,
    input  Entrada,
    input  Controle,
    input  Pressionado
  );

  modport slave (
    input  Bruto,
    output Entrada,
    output Controle,
    output Pressionado
  );

endinterface

// File: rtl/amostrador_entrada_sincronizador.sv
// Two-flop synchroniser for the raw code lines; Reset clears both stages.
// Ports: clk, Reset (sync, active-high), d (async in), q (synced out).
module sincronizador #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/amostrador_entrada.sv
// Input sampler: sync, debounce, one Controle strobe per accepted press.
// Ports: clk, Reset (sync high), bus (Bruto in; Entrada/Controle/Pressionado out).
// AMOSTRADOR_REPEAT_EN adds auto-repeat strobes while a code is held.
module amostrador_entrada
  import amostrador_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_CYC   = 200
) (
  input  logic         clk,
  input  logic         Reset,
  amostrador_if.slave  bus
);

  localparam int CW = cnt_bits(DEBOUNCE_CYC, REPEAT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [WIDTH-1:0] IDLE = WIDTH'(CODE_IDLE);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] entrada;
  logic [CW-1:0]    cnt;
  logic             controle;
  estado_t          state;

`ifdef AMOSTRADOR_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYC - 1);
  logic [CW-1:0] rpt;
`endif

  sincronizador #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .Reset (Reset),
    .d     (bus.Bruto),
    .q     (s2)
  );

  assign bus.Entrada     = entrada;
  assign bus.Controle    = controle;
  assign bus.Pressionado = (state == EMITIDO) ||
                           (state == LIBERANDO);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= OCIOSO;
      cand     <= '0;
      cnt      <= '0;
      entrada  <= '0;
      controle <= 1'b0;
`ifdef AMOSTRADOR_REPEAT_EN
      rpt      <= '0;
`endif
    end else begin
      controle <= 1'b0;
      unique case (state)
        OCIOSO: begin
          if (s2 != IDLE) begin
            state <= FILTRANDO;
            cand  <= s2;
            cnt   <= '0;
          end
        end
        FILTRANDO: begin
          if (s2 == IDLE) begin
            state <= OCIOSO;
          end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            entrada  <= cand;
            controle <= 1'b1;
            state    <= EMITIDO;
          end
        end
        EMITIDO: begin
          if (s2 != entrada) begin
            state <= LIBERANDO;
            cand  <= s2;
            cnt   <= '0;
`ifdef AMOSTRADOR_REPEAT_EN
            rpt   <= '0;
`endif
          end
`ifdef AMOSTRADOR_REPEAT_EN
          else if (rpt == RPT_LAST) begin
            controle <= 1'b1;
            rpt      <= '0;
          end else begin
            rpt <= rpt + 1'b1;
          end
`endif
        end
        LIBERANDO: begin
          // Return to the held code is a glitch: no new strobe.
          if (s2 == entrada) begin
            state <= EMITIDO;
          end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (cand == IDLE) begin
            state <= OCIOSO;
          end else begin
            // Slide straight to a new code counts as a press.
            entrada  <= cand;
            controle <= 1'b1;
            state    <= EMITIDO;
          end
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_amostrador_entrada.sv
// Bench for amostrador_entrada: directed segment table plus random presses
// compared every cycle against a run-length model of the debounce rules.
module tb_amostrador_entrada;

  localparam int W = 7;
  localparam int D = 4;
  localparam int R = 10;

`ifdef AMOSTRADOR_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  amostrador_if #(.WIDTH(W)) bus ();

  amostrador_entrada #(
    .WIDTH        (W),
    .DEBOUNCE_CYC (D),
    .REPEAT_CYC   (R)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: synced samples, run length of the current sample value,
  // accepted code, pressed flag, hold counter for auto-repeat.
  logic [W-1:0] m_s1, m_s2, m_prev, m_ent;
  logic         m_ctl, m_prs;
  int           m_run, m_hold;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] b, input logic r);
    logic [W-1:0] v;
    logic         same;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_ent = '0;
      m_ctl = 1'b0; m_prs = 1'b0; m_run = 0; m_hold = 0;
      return;
    end
    v    = m_s2;
    same = (v == m_prev);
    m_run = same ? m_run + 1 : 1;
    m_ctl = 1'b0;
    if (!m_prs) begin
      if (v != '0 && m_run == D + 1) begin
        m_ent = v; m_ctl = 1'b1; m_prs = 1'b1; m_hold = 0;
      end
    end else if (v == m_ent) begin
      m_hold = same ? m_hold + 1 : 0;
      if (RPT && m_hold == R) begin
        m_ctl = 1'b1; m_hold = 0;
      end
    end else begin
      m_hold = 0;
      if (m_run == D + 1) begin
        if (v == '0) begin
          m_prs = 1'b0;
        end else begin
          m_ent = v; m_ctl = 1'b1; m_hold = 0;
        end
      end
    end
    m_prev = v;
    m_s2   = m_s1;
    m_s1   = b;
  endtask

  task automatic step(input logic [W-1:0] b, input logic r,
                      output logic ctl);
    bus.Bruto = b;
    Reset     = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    chk("Entrada", 32'(bus.Entrada), 32'(m_ent));
    chk("Controle", 32'(bus.Controle), 32'(m_ctl));
    chk("Pressionado", 32'(bus.Pressionado), 32'(m_prs));
    ctl = bus.Controle;
  endtask

  typedef struct {
    logic [W-1:0] b;
    logic         rst;
    int           cyc;
    int           p_off;
    int           p_on;
    int           first;
    logic [W-1:0] ent;
    logic         prs;
  } seg_t;

  seg_t tbl[$];

  initial begin
    logic c;
    int   pulses, first, code, len;
    logic [W-1:0] codes [4];

    bus.Bruto = '0;
    Reset     = 1'b1;

    tbl.push_back('{7'b0000000, 1'b1,  2, 0, 0, -1, 7'b0000000, 1'b0});
    tbl.push_back('{7'b0000000, 1'b0,  5, 0, 0, -1, 7'b0000000, 1'b0});
    tbl.push_back('{7'b1100000, 1'b0, 20, 1, 2,  7, 7'b1100000, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1100000, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tbl.push_back('{7'b1000100, 1'b0, 2, 0, 0, -1, 7'b1100000, 1'b0});
      tbl.push_back('{7'b0000000, 1'b0, 2, 0, 0, -1, 7'b1100000, 1'b0});
    end
    tbl.push_back('{7'b1000100, 1'b0, 20, 1, 2,  7, 7'b1000100, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1000100, 1'b0});
    tbl.push_back('{7'b1111100, 1'b0, 12, 1, 1,  7, 7'b1111100, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0,  1, 0, 0, -1, 7'b1111100, 1'b1});
    tbl.push_back('{7'b1111100, 1'b0,  8, 0, 0, -1, 7'b1111100, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1111100, 1'b0});
    tbl.push_back('{7'b1111100, 1'b0, 12, 1, 1,  7, 7'b1111100, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1111100, 1'b0});
    tbl.push_back('{7'b1011010, 1'b0, 12, 1, 1,  7, 7'b1011010, 1'b1});
    tbl.push_back('{7'b1101110, 1'b0, 12, 1, 1,  7, 7'b1101110, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1101110, 1'b0});
    tbl.push_back('{7'b0110011, 1'b0,  4, 0, 0, -1, 7'b1101110, 1'b0});
    tbl.push_back('{7'b0110011, 1'b1,  1, 0, 0, -1, 7'b0000000, 1'b0});
    tbl.push_back('{7'b0110011, 1'b0, 10, 1, 1,  7, 7'b0110011, 1'b1});
    tbl.push_back('{7'b0110011, 1'b1,  1, 0, 0, -1, 7'b0000000, 1'b0});
    tbl.push_back('{7'b0110011, 1'b0, 10, 1, 1,  7, 7'b0110011, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b0110011, 1'b0});
    tbl.push_back('{7'b1110101, 1'b0, 40, 1, 4,  7, 7'b1110101, 1'b1});
    tbl.push_back('{7'b0000000, 1'b0, 10, 0, 0, -1, 7'b1110101, 1'b0});

    foreach (tbl[i]) begin
      pulses = 0;
      first  = -1;
      for (int k = 1; k <= tbl[i].cyc; k++) begin
        step(tbl[i].b, tbl[i].rst, c);
        if (c === 1'b1) begin
          pulses++;
          if (first < 0) first = k;
        end
      end
      chk($sformatf("seg%0d pulses", i), 32'(pulses),
          32'(RPT ? tbl[i].p_on : tbl[i].p_off));
      chk($sformatf("seg%0d first", i), 32'(first), 32'(tbl[i].first));
      chk($sformatf("seg%0d Entrada", i), 32'(bus.Entrada), 32'(tbl[i].ent));
      chk($sformatf("seg%0d Pressionado", i), 32'(bus.Pressionado),
          32'(tbl[i].prs));
    end

    codes[0] = 7'b0000000;
    codes[1] = 7'b0101010;
    codes[2] = 7'b1010101;
    codes[3] = 7'b0011001;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 24) == 0) step(codes[0], 1'b1, c);
      code = $urandom_range(0, 3);
      len  = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) step(codes[code], 1'b0, c);
    end
    for (int k = 0; k < 12; k++) step(codes[0], 1'b0, c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
